chip_gate_tester: RTL and testbench

Parametrised, self-sequencing tester for a bank of 2-input logic gates such as a quad AND chip model or a physical 74-series part wired to GPIO. On `start`, it drives every input combination onto `CHANNELS` gate pairs, waits a settle interval, and compares each returned output against the selected gate function. It reports pass/fail, a per-channel failure mask and the first failing vector. It sits between lab switch/key logic and the device under test (DUT), replacing manual truth-table checking.

---
 rtl/chip_gate_tester.sv | 176 +++++++++++++++++
 tb/tb_chip_gate_tester.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip_gate_tester.sv
// chip_gate_tester: self-sequencing truth-table tester for CHANNELS 2-input gates.
// Each test vector is held for SETTLE cycles and then sampled once. Mismatches
// are ORed into a per-channel mask, and the index of the first failing vector
// is captured.
// Optional feature: define CHIP_GATE_TESTER_WALK_EN to append CHANNELS one-hot
// walk vectors after the four base vectors. These catch bridged or swapped pins.

// Per-channel comparator: expected gate output vs returned DUT bit.
module chip_gate_lane (
  input  logic [2:0] fn,
  input  logic       a,
  input  logic       b,
  input  logic       m,
  output logic       miss
);
  logic e;

  // Expected output of the latched gate function for this channel.
  always_comb begin
    e = 1'b0;
    case (fn)
      3'd0:    e = a & b;
      3'd1:    e = a | b;
      3'd2:    e = a ^ b;
      3'd3:    e = ~(a & b);
      3'd4:    e = ~(a | b);
      3'd5:    e = ~(a ^ b);
      default: e = 1'b0;
    endcase
  end

  assign miss = (m != e);
endmodule

module chip_gate_tester #(
  parameter int CHANNELS = 4,
  parameter int SETTLE   = 3,
  parameter int VW       = $clog2(4 + CHANNELS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [2:0]          func,
  output logic [CHANNELS-1:0] x,
  output logic [CHANNELS-1:0] y,
  input  logic [CHANNELS-1:0] m,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                err,
  output logic [CHANNELS-1:0] fail_mask,
  output logic [VW-1:0]       fail_vec
);
`ifdef CHIP_GATE_TESTER_WALK_EN
  localparam int NVEC = 4 + CHANNELS;
`else
  localparam int NVEC = 4;
`endif
  localparam logic [VW-1:0] LAST = VW'(NVEC - 1);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t              state;
  logic [VW-1:0]       k;
  logic [VW-1:0]       k_nxt;
  logic [CW-1:0]       cnt;
  logic [2:0]          fn;
  logic [CHANNELS-1:0] miss;
  logic                func_ok;

  assign k_nxt   = k + 1'b1;
  assign func_ok = (func <= 3'd5);

  // Vector k < 4 replicates k[1] onto A. Walk vectors are one-hot on channel k-4.
  function automatic logic [CHANNELS-1:0] vec_a(input logic [VW-1:0] kk);
    logic [CHANNELS-1:0] v;
    v = '0;
    if (kk < VW'(4)) v = {CHANNELS{kk[1]}};
    else for (int i = 0; i < CHANNELS; i++) v[i] = (kk == VW'(4 + i));
    return v;
  endfunction

  // B input: base vectors replicate k[0]. Walk vectors use the same one-hot as A.
  function automatic logic [CHANNELS-1:0] vec_b(input logic [VW-1:0] kk);
    logic [CHANNELS-1:0] v;
    v = '0;
    if (kk < VW'(4)) v = {CHANNELS{kk[0]}};
    else for (int i = 0; i < CHANNELS; i++) v[i] = (kk == VW'(4 + i));
    return v;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    chip_gate_lane u_lane (
      .fn   (fn),
      .a    (x[i]),
      .b    (y[i]),
      .m    (m[i]),
      .miss (miss[i])
    );
  end

  // Sequencer FSM. All outputs are registered and change only on state entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      fn        <= '0;
      x         <= '0;
      y         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= 1'b0;
      fail_mask <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (func_ok) begin
              state     <= DRIVE;
              fn        <= func;
              k         <= '0;
              cnt       <= CW'(SETTLE - 1);
              x         <= vec_a('0);
              y         <= vec_b('0);
              busy      <= 1'b1;
              done      <= 1'b0;
              pass      <= 1'b0;
              err       <= 1'b0;
              fail_mask <= '0;
              fail_vec  <= '0;
            end else begin
              // Invalid function: report immediately without driving the DUT.
              state     <= DONE;
              x         <= '0;
              y         <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= 1'b0;
              err       <= 1'b1;
              fail_mask <= '1;
              fail_vec  <= '0;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        SAMPLE: begin
          fail_mask <= fail_mask | miss;
          // An empty mask means no earlier vector has failed.
          if ((|miss) && (fail_mask == '0)) fail_vec <= k;
          if (k == LAST) begin
            state <= DONE;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ((fail_mask | miss) == '0);
          end else begin
            state <= DRIVE;
            k     <= k_nxt;
            cnt   <= CW'(SETTLE - 1);
            x     <= vec_a(k_nxt);
            y     <= vec_b(k_nxt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chip_gate_tester.sv
// Self-checking bench for chip_gate_tester. The bench models a gate chip with
// configurable function, stuck-at faults and a bridge between channels 0/1.
// Expected results come from walking the vector list directly.
module tb_chip_gate_tester;
  localparam int CH = 4;
  localparam int S  = 3;
  localparam int VW = $clog2(4 + CH);
`ifdef CHIP_GATE_TESTER_WALK_EN
  localparam int NV = 4 + CH;
`else
  localparam int NV = 4;
`endif
  localparam int LAT = NV * (S + 1);
  localparam int LIM = 400;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    func = 3'd0;
  logic [CH-1:0] xo, yo, mo, fail_mask;
  logic          busy, done, pass, err;
  logic [VW-1:0] fail_vec;

  int            chip_f = 0;
  logic [CH-1:0] sm_r = '0, sv_r = '0;
  logic          br_r = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  chip_gate_tester #(.CHANNELS(CH), .SETTLE(S)) dut (
    .clk(clk), .resetn(resetn), .start(start), .func(func),
    .x(xo), .y(yo), .m(mo), .busy(busy), .done(done), .pass(pass),
    .err(err), .fail_mask(fail_mask), .fail_vec(fail_vec)
  );

  // Truth table per function, indexed by {a,b}.
  function automatic logic [3:0] tt(input int f);
    case (f)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0110;
      3: return 4'b0111;
      4: return 4'b0001;
      5: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [CH-1:0] chip_resp(input logic [CH-1:0] a, b, input int cf,
                                              input logic [CH-1:0] sm, sv, input logic br);
    logic [CH-1:0] r;
    logic [3:0] t;
    logic o;
    t = tt(cf);
    for (int i = 0; i < CH; i++) r[i] = t[{a[i], b[i]}];
    r = (r & ~sm) | (sv & sm);
    if (br) begin o = r[0] | r[1]; r[0] = o; r[1] = o; end
    return r;
  endfunction

  assign mo = chip_resp(xo, yo, chip_f, sm_r, sv_r, br_r);

  task automatic ref_model(input int tf, input int cf, input logic [CH-1:0] sm, sv,
                           input logic br, output logic [CH-1:0] emask, output int evec,
                           output logic epass);
    logic [CH-1:0] a, b, got, want;
    logic [3:0] t;
    emask = '0; evec = 0; t = tt(tf);
    for (int k = 0; k < NV; k++) begin
      if (k < 4) begin
        a = ((k / 2) % 2 == 1) ? '1 : '0;
        b = (k % 2 == 1) ? '1 : '0;
      end else begin
        a = CH'(1) << (k - 4);
        b = a;
      end
      got = chip_resp(a, b, cf, sm, sv, br);
      for (int i = 0; i < CH; i++) want[i] = t[{a[i], b[i]}];
      if (got != want && emask == '0) evec = k;
      emask |= got ^ want;
    end
    epass = (emask == '0);
  endtask

  // Pulse start, then wait (bounded) for done. lat counts edges after the start edge.
  task automatic run(input logic [2:0] f, output int lat, output logic b0,
                     output logic [CH-1:0] x0, y0, output logic bseen);
    @(negedge clk); func = f; start = 1'b1;
    @(negedge clk); start = 1'b0;
    b0 = busy; x0 = xo; y0 = yo; bseen = busy; lat = 0;
    while (!done && lat < LIM) begin @(negedge clk); lat++; bseen |= busy; end
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, err, xo, yo, fail_mask, fail_vec} !== '0) begin
      errors++; $display("FAIL reset_outputs got busy%b done%b pass%b err%b x%h y%h mask%h vec%0d want all 0",
                         busy, done, pass, err, xo, yo, fail_mask, fail_vec);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and_ideal;
    int lat; logic b0, bs; logic [CH-1:0] x0, y0;
    chip_f = 0; sm_r = '0; sv_r = '0; br_r = 1'b0;
    run(3'd0, lat, b0, x0, y0, bs);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL and_latency got %0d want %0d", lat, LAT); end
    checks++; if (b0 !== 1'b1 || x0 !== '0 || y0 !== '0) begin errors++; $display("FAIL and_first_vec got busy%b x%h y%h want 1 0 0", b0, x0, y0); end
    checks++; if (pass !== 1'b1 || fail_mask !== '0 || fail_vec !== '0 || busy !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL and_result got pass%b mask%b vec%0d busy%b err%b want 1 0000 0 0 0", pass, fail_mask, fail_vec, busy, err); end
  endtask

  task automatic test_stuck;
    int lat; logic b0, bs; logic [CH-1:0] x0, y0;
    chip_f = 0; sm_r = 4'b0100; sv_r = '0; br_r = 1'b0;
    run(3'd0, lat, b0, x0, y0, bs);
    checks++; if (pass !== 1'b0 || fail_mask !== 4'b0100 || fail_vec !== VW'(3))
      begin errors++; $display("FAIL stuck_ch2 got pass%b mask%b vec%0d want 0 0100 3", pass, fail_mask, fail_vec); end
    sm_r = '0;
  endtask

  task automatic test_xor_on_and;
    int lat; logic b0, bs; logic [CH-1:0] x0, y0;
    chip_f = 0;
    run(3'd2, lat, b0, x0, y0, bs);
    checks++; if (pass !== 1'b0 || fail_mask !== 4'b1111 || fail_vec !== VW'(1))
      begin errors++; $display("FAIL xor_vs_and got pass%b mask%b vec%0d want 0 1111 1", pass, fail_mask, fail_vec); end
  endtask

  task automatic test_invalid;
    int lat; logic b0, bs; logic [CH-1:0] x0, y0;
    for (int f = 6; f < 8; f++) begin
      run(3'(f), lat, b0, x0, y0, bs);
      checks++; if (lat > 1 || done !== 1'b1 || err !== 1'b1 || pass !== 1'b0 || fail_mask !== '1 || fail_vec !== '0)
        begin errors++; $display("FAIL invalid_func%0d got lat%0d done%b err%b pass%b mask%b vec%0d want <=1 1 1 0 1111 0",
                                 f, lat, done, err, pass, fail_mask, fail_vec); end
      checks++; if (bs !== 1'b0) begin errors++; $display("FAIL invalid_busy%0d got %b want 0", f, bs); end
    end
  endtask

  task automatic test_reset_mid;
    chip_f = 0;
    @(negedge clk); func = 3'd0; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin @(negedge clk); start = (i % 2 == 1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy); end
    @(negedge clk); resetn = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, err, xo, yo, fail_mask, fail_vec} !== '0) begin
      errors++; $display("FAIL midreset_outputs got busy%b done%b pass%b err%b x%h y%h mask%h vec%0d want all 0",
                         busy, done, pass, err, xo, yo, fail_mask, fail_vec);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_idle got busy%b done%b want 0 0", busy, done); end
  endtask

  // Start pulses and func changes while busy must not disturb the run.
  task automatic test_busy_ignores;
    int lat;
    chip_f = 0;
    @(negedge clk); func = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 0;
    while (!done && lat < LIM) begin
      start = (lat % 3 == 1); func = 3'(lat % 8);
      @(negedge clk); lat++;
    end
    start = 1'b0; func = 3'd0;
    checks++; if (lat !== LAT) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", lat, LAT); end
    checks++; if (pass !== 1'b1 || fail_mask !== '0 || err !== 1'b0)
      begin errors++; $display("FAIL busy_func_change got pass%b mask%b err%b want 1 0000 0", pass, fail_mask, err); end
  endtask

  task automatic test_bridge;
    int lat, evec; logic b0, bs, epass; logic [CH-1:0] x0, y0, emask;
    chip_f = 0; br_r = 1'b1;
    ref_model(0, 0, '0, '0, 1'b1, emask, evec, epass);
    run(3'd0, lat, b0, x0, y0, bs);
    checks++; if (pass !== epass || fail_mask !== emask || fail_vec !== VW'(evec))
      begin errors++; $display("FAIL bridge01 got pass%b mask%b vec%0d want %b %b %0d", pass, fail_mask, fail_vec, epass, emask, evec); end
    br_r = 1'b0;
  endtask

  task automatic test_random;
    int lat, evec, tf; logic b0, bs, epass; logic [CH-1:0] x0, y0, emask;
    for (int n = 0; n < 24; n++) begin
      tf = $urandom_range(0, 5);
      chip_f = $urandom_range(0, 5);
      sm_r = ($urandom_range(0, 1) == 1) ? CH'($urandom) : '0;
      sv_r = CH'($urandom);
      br_r = ($urandom_range(0, 3) == 0);
      ref_model(tf, chip_f, sm_r, sv_r, br_r, emask, evec, epass);
      run(3'(tf), lat, b0, x0, y0, bs);
      checks++;
      if (lat !== LAT || pass !== epass || fail_mask !== emask || fail_vec !== VW'(evec) || err !== 1'b0)
        begin errors++; $display("FAIL random%0d tf%0d cf%0d got lat%0d pass%b mask%b vec%0d err%b want %0d %b %b %0d 0",
                                 n, tf, chip_f, lat, pass, fail_mask, fail_vec, err, LAT, epass, emask, evec); end
    end
    sm_r = '0; br_r = 1'b0; chip_f = 0;
  endtask

  task automatic test_back_to_back;
    int lat;
    chip_f = 0;
    @(negedge clk); func = 3'd0; start = 1'b1;
    @(negedge clk); lat = 0;
    while (!done && lat < LIM) begin @(negedge clk); lat++; end
    checks++; if (lat !== LAT || pass !== 1'b1) begin errors++; $display("FAIL b2b_first got lat%0d pass%b want %0d 1", lat, pass, LAT); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy%b done%b want 1 0", busy, done); end
    start = 1'b0; lat = 0;
    while (!done && lat < LIM) begin @(negedge clk); lat++; end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL b2b_second got done%b pass%b want 1 1", done, pass); end
  endtask

  initial begin
    test_reset;
    test_and_ideal;
    test_stuck;
    test_xor_on_and;
    test_invalid;
    test_and_ideal;
    test_reset_mid;
    test_busy_ignores;
    test_bridge;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
